// File: rtl/spikey_spi_pkg.sv
// spikey_spi_pkg: shared FSM states and defaults for the SPI target
package spikey_spi_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int SPI_MODE = 0;
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/spikey_spi_sync.sv
// spikey_spi_sync: multi-flop synchronizer with rise/fall detect on the synced value
module spikey_spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic FCLK,
  input  logic RST_N,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES:0] sh;
  always_ff @(posedge FCLK or negedge RST_N)
    if (!RST_N) sh <= {(STAGES+1){RST_VAL}};
    else sh <= {sh[STAGES-1:0], d};
  assign q    = sh[STAGES-1];
  assign rise = q & ~sh[STAGES];
  assign fall = ~q & sh[STAGES];
endmodule

// File: rtl/spikey_spi_target.sv
// spikey_spi_target: SPI mode-0 target with one-entry tx buffer and rx word output
module spikey_spi_target
  import spikey_spi_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              FCLK,
  input  logic              RST_N,
  input  logic              SCLK,
  input  logic              CS_N,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_OE,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_err
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  state_t state, state_nx;
  logic sclk_q, sclk_rise, sclk_fall, cs_q, cs_rise, cs_fall, mosi, mosi_rise, mosi_fall;
  logic [CW-1:0] bit_cnt;
  logic [DATA_W-1:0] rx_shift, tx_shift, tx_buf;
  logic tx_full, reload;
  logic unused_sync;
  spikey_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .FCLK(FCLK), .RST_N(RST_N), .d(SCLK), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
  spikey_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .FCLK(FCLK), .RST_N(RST_N), .d(CS_N), .q(cs_q), .rise(cs_rise), .fall(cs_fall));
  spikey_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .FCLK(FCLK), .RST_N(RST_N), .d(MOSI), .q(mosi), .rise(mosi_rise), .fall(mosi_fall));
  assign unused_sync = ^{sclk_q, cs_q, mosi_rise, mosi_fall};
  always_ff @(posedge FCLK or negedge RST_N)
    if (!RST_N) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = cs_fall ? SHIFT : cs_rise ? IDLE : state;
  end
  logic shifting, rx_edge, wrap, load;
  assign shifting = state == SHIFT;
  assign rx_edge  = shifting & sclk_rise;
  assign wrap     = rx_edge & (bit_cnt == LAST);
  // the falling edge right after a wrap starts the next word instead of shifting
  assign load     = cs_fall | (shifting & sclk_fall & reload);
  assign MISO     = tx_shift[DATA_W-1];
  assign MISO_OE  = shifting;
  assign tx_ready = ~tx_full;
  always_ff @(posedge FCLK or negedge RST_N)
    if (!RST_N) begin
      bit_cnt     <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;
      tx_shift    <= '0;
      tx_buf      <= '0;
      tx_full     <= 1'b0;
      reload      <= 1'b0;
    end else begin
      rx_valid    <= wrap;
      frame_err   <= shifting & cs_rise & (bit_cnt != '0);
      tx_underrun <= load & ~tx_full & ~tx_valid;
      if (shifting & cs_rise) begin
        bit_cnt <= '0;
        reload  <= 1'b0;
      end else if (rx_edge) begin
        rx_shift <= {rx_shift[DATA_W-2:0], mosi};
        bit_cnt  <= wrap ? '0 : bit_cnt + 1'b1;
        if (wrap) begin
          rx_data <= {rx_shift[DATA_W-2:0], mosi};
          reload  <= 1'b1;
        end
      end
      if (load) begin
        tx_shift <= tx_full ? tx_buf : tx_valid ? tx_data : '0;
        tx_full  <= 1'b0;
        reload   <= 1'b0;
      end else begin
        if (shifting & sclk_fall) tx_shift <= tx_shift << 1;
        if (tx_valid & ~tx_full) begin
          tx_buf  <= tx_data;
          tx_full <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_spikey_spi_target.sv
// tb_spikey_spi_target: scoreboard bench driving a mode-0 FCLK/8 initiator
module tb_spikey_spi_target;
  localparam int W = 8, H = 4, SS = 2;
  logic FCLK = 0, RST_N = 0, SCLK = 0, CS_N = 1, MOSI = 0, tx_valid = 0;
  logic [W-1:0] tx_data = '0;
  logic MISO, MISO_OE, tx_ready, rx_valid, tx_underrun, frame_err;
  logic [W-1:0] rx_data;
  int n_chk = 0, n_pass = 0, n_rxv = 0, n_ferr = 0, n_und = 0;
  int r0, f0, u0;
  logic [W-1:0] rx_q[$];

  spikey_spi_target #(.DATA_W(W), .SYNC_STAGES(SS)) dut (
    .FCLK(FCLK), .RST_N(RST_N), .SCLK(SCLK), .CS_N(CS_N), .MOSI(MOSI),
    .MISO(MISO), .MISO_OE(MISO_OE), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_underrun(tx_underrun), .frame_err(frame_err));

  always #5 FCLK = ~FCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge FCLK) begin
    if (rx_valid) begin
      n_rxv++;
      if (rx_q.size() != 0) check("rx_data", rx_data, rx_q.pop_front());
      else check("rx_spurious", rx_valid, 0);
    end
    if (frame_err) n_ferr++;
    if (tx_underrun) n_und++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge FCLK);
    #1;
  endtask

  task automatic tx_put(input logic [W-1:0] w);
    int t = 0;
    while (!tx_ready && t < 100) begin cyc(1); t++; end
    if (t >= 100) check("tx_ready_wait", tx_ready, 1);
    tx_data = w; tx_valid = 1;
    cyc(1);
    tx_valid = 0;
  endtask

  task automatic cs_low();
    CS_N = 0;
    cyc(H);
  endtask

  task automatic cs_high();
    cyc(H);
    CS_N = 1;
    cyc(2*H);
  endtask

  task automatic bits(input logic [W-1:0] mo, input int n, input logic [W-1:0] mi,
                      input bit chk_mi, input string tag);
    for (int i = 0; i < n; i++) begin
      MOSI = mo[W-1-i];
      cyc(H);
      if (chk_mi) check($sformatf("%s_b%0d", tag, i), MISO, mi[W-1-i]);
      SCLK = 1;
      cyc(H);
      SCLK = 0;
    end
  endtask

  initial begin
    cyc(3);
    check("rst_miso", MISO, 0);
    check("rst_oe", MISO_OE, 0);
    check("rst_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_underrun", tx_underrun, 0);
    check("rst_frame_err", frame_err, 0);
    RST_N = 1;
    cyc(5);

    // preloaded A5, receive 3C
    tx_put(8'hA5);
    check("t1_full", tx_ready, 0);
    r0 = n_rxv;
    cs_low();
    check("t1_oe", MISO_OE, 1);
    rx_q.push_back(8'h3C);
    bits(8'h3C, 8, 8'hA5, 1, "t1_miso");
    cs_high();
    check("t1_oe_off", MISO_OE, 0);
    check("t1_rx_pulses", n_rxv - r0, 1);

    // back-to-back frames with two queued tx words
    tx_put(8'hF0);
    r0 = n_rxv;
    cs_low();
    tx_put(8'h0F);
    rx_q.push_back(8'h01);
    rx_q.push_back(8'h80);
    bits(8'h01, 8, 8'hF0, 1, "t2a_miso");
    bits(8'h80, 8, 8'h0F, 1, "t2b_miso");
    cs_high();
    check("t2_rx_pulses", n_rxv - r0, 2);

    // underrun: nothing to send
    check("t3_empty", tx_ready, 1);
    u0 = n_und; r0 = n_rxv;
    cs_low();
    check("t3_underrun_once", n_und - u0, 1);
    rx_q.push_back(8'h96);
    bits(8'h96, 8, 8'h00, 1, "t3_miso");
    cs_high();
    check("t3_rx_pulses", n_rxv - r0, 1);

    // truncated frame then a good one
    f0 = n_ferr; r0 = n_rxv;
    cs_low();
    bits(8'hB7, 5, 8'h00, 0, "t4");
    cs_high();
    check("t4_frame_err", n_ferr - f0, 1);
    check("t4_no_rx", n_rxv - r0, 0);
    rx_q.push_back(8'h55);
    cs_low();
    bits(8'h55, 8, 8'h00, 0, "t4b");
    cs_high();
    check("t4b_rx_pulses", n_rxv - r0, 1);
    check("t4b_frame_err", n_ferr - f0, 1);

    // bypass: tx_valid exactly in the CS_N-fall load cycle
    check("t5_pre_ready", tx_ready, 1);
    u0 = n_und; r0 = n_rxv;
    CS_N = 0;
    cyc(SS);
    tx_data = 8'hC3; tx_valid = 1;
    cyc(1);
    tx_valid = 0;
    check("t5_ready", tx_ready, 1);
    check("t5_miso_first", MISO, 1);
    cyc(1);
    check("t5_no_underrun", n_und - u0, 0);
    rx_q.push_back(8'h5A);
    bits(8'h5A, 8, 8'hC3, 1, "t5_miso");
    cs_high();
    check("t5_rx_pulses", n_rxv - r0, 1);

    // reset mid-frame
    cs_low();
    tx_put(8'h77);
    bits(8'h33, 4, 8'h00, 0, "t6");
    check("t6_pre_ready", tx_ready, 0);
    check("t6_pre_oe", MISO_OE, 1);
    #2 RST_N = 0;
    #1;
    check("t6_miso", MISO, 0);
    check("t6_oe", MISO_OE, 0);
    check("t6_ready", tx_ready, 1);
    check("t6_rx_data", rx_data, 0);
    check("t6_rx_valid", rx_valid, 0);
    check("t6_underrun", tx_underrun, 0);
    check("t6_frame_err", frame_err, 0);
    CS_N = 1; SCLK = 0;
    cyc(3);
    RST_N = 1;
    r0 = n_rxv; f0 = n_ferr;
    cyc(30);
    check("t6_no_rx", n_rxv - r0, 0);
    check("t6_no_ferr", n_ferr - f0, 0);
    rx_q.push_back(8'hE7);
    cs_low();
    bits(8'hE7, 8, 8'h00, 0, "t6b");
    cs_high();
    check("t6b_rx_pulses", n_rxv - r0, 1);
    check("t6b_no_ferr", n_ferr - f0, 0);

    check("rx_queue_empty", rx_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end
endmodule
